// File: rtl/mult_booth.sv
// Sequential signed 32x32 radix-2 Booth multiplier: one iteration per clock over 32 cycles,
// 64-bit product registered into hi/lo with a one-cycle done pulse.
module mult_booth (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [32:0] r_a;
   logic [32:0] r_m;
   logic [31:0] r_q;
   logic        r_q_1;
   logic [5:0]  r_count;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [32:0] w_sum;
   logic [32:0] w_a_next;
   logic [31:0] w_q_next;

   // Booth add/subtract selected by the current multiplier bit pair
   always_comb begin
      w_sum = r_a;
      case ({r_q[0], r_q_1})
         2'b01:   w_sum = r_a + r_m;
         2'b10:   w_sum = r_a - r_m;
         default: w_sum = r_a;
      endcase
   end

   assign w_a_next = {w_sum[32], w_sum[32:1]};
   assign w_q_next = {w_sum[0], r_q[31:1]};

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_a     <= 33'd0;
         r_m     <= 33'd0;
         r_q     <= 32'd0;
         r_q_1   <= 1'b0;
         r_count <= 6'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_a     <= w_a_next;
               r_q     <= w_q_next;
               r_q_1   <= r_q[0];
               r_count <= r_count + 6'd1;
               if (r_count == 6'd31) begin
                  r_hi    <= w_a_next[31:0];
                  r_lo    <= w_q_next;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            // The edge leaving DONE is the IDLE re-entry edge, so a start seen there is
            // accepted directly; this keeps back-to-back throughput at one product per 33 cycles.
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_m     <= {a_in[31], a_in};
                  r_q     <= b_in;
                  r_a     <= 33'd0;
                  r_q_1   <= 1'b0;
                  r_count <= 6'd0;
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed vector table, random operands against an
// arithmetic reference product, and hand-written start/reset/back-to-back sequences.
module tb_mult_booth;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a_in = 32'd0;
   logic [31:0] b_in = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests = 0;
   int n_fail  = 0;

   mult_booth dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
      longint pa;
      longint pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
   endfunction

   // One multiply: returns the result, cycles from start edge to done, and busy cycles seen
   task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l,
                          output int lat, output int busy_cnt);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      a_in     = $urandom;
      b_in     = $urandom;
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      h = hi;
      l = lo;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] h;
      logic [31:0] l;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] corner[5];
      logic [63:0] p;
      int lat;
      int bc;
      int dcount;
      int bcount;
      int pulses[$];
      int unstable;

      vecs[0] = '{32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[2] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
      vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[5] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
      vecs[6] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[7] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      corner[0] = 32'h80000000;
      corner[1] = 32'h7FFFFFFF;
      corner[2] = 32'h00000000;
      corner[3] = 32'h00000001;
      corner[4] = 32'hFFFFFFFF;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_mult(vecs[i].a, vecs[i].b, h, l, lat, bc);
         check($sformatf("vec%0d_hilo", i), {h, l}, {vecs[i].hi, vecs[i].lo});
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
         check($sformatf("vec%0d_busy", i), 64'(bc), 64'd32);
      end

      for (int i = 0; i < 30; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         p  = ref_prod(ra, rb);
         do_mult(ra, rb, h, l, lat, bc);
         check($sformatf("rand%0d_%08h_x_%08h", i, ra, rb), {h, l}, p);
         check($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
      end

      // start during RUN is ignored and operand changes after the start edge have no effect
      @(negedge clk);
      a_in = 32'd5;
      b_in = 32'd6;
      start = 1'b1;
      dcount = 0;
      bcount = 0;
      h = 32'hDEADBEEF;
      l = 32'hDEADBEEF;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) start = 1'b0;
         if (c == 3) begin
            start = 1'b1;
            a_in  = 32'd9;
            b_in  = 32'd9;
         end
         if (c == 4) start = 1'b0;
         if (c > 4) begin
            a_in = $urandom;
            b_in = $urandom;
         end
         if (busy) bcount++;
         if (done) begin
            dcount++;
            h = hi;
            l = lo;
         end
      end
      check("ignore_done_count", 64'(dcount), 64'd1);
      check("ignore_busy_cycles", 64'(bcount), 64'd32);
      check("ignore_hilo", {h, l}, {32'h0, 32'h0000001E});

      // reset in the middle of RUN abandons the multiply
      @(negedge clk);
      a_in = 32'd7;
      b_in = 32'd11;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("midrun_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      dcount = 0;
      bcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
         if (busy) bcount++;
      end
      check("rst_no_done", 64'(dcount), 64'd0);
      check("rst_no_busy", 64'(bcount), 64'd0);
      do_mult(32'd2, 32'd3, h, l, lat, bc);
      check("post_rst_hilo", {h, l}, 64'd6);

      // back-to-back with start held high
      @(negedge clk);
      a_in = 32'd3;
      b_in = 32'd4;
      start = 1'b1;
      unstable = 0;
      for (int c = 0; c < 105; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses.push_back(c);
            check($sformatf("b2b_hilo_%0d", pulses.size()), {hi, lo}, 64'd12);
         end else if (pulses.size() > 0 && {hi, lo} !== 64'd12) begin
            unstable++;
         end
      end
      start = 1'b0;
      check("b2b_pulse_count", 64'(pulses.size()), 64'd3);
      if (pulses.size() == 3) begin
         check("b2b_first", 64'(pulses[0]), 64'd32);
         check("b2b_period1", 64'(pulses[1] - pulses[0]), 64'd33);
         check("b2b_period2", 64'(pulses[2] - pulses[1]), 64'd33);
      end
      check("b2b_stable", 64'(unstable), 64'd0);
      repeat (40) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
